// File: rtl/mem_access_pkg.sv
// Shared types for the memory access unit: FSM state encoding, access-type
// constants and the base-select width helper.
package mem_access_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    typedef logic acc_t;

    localparam acc_t ACC_RD = 1'b0;
    localparam acc_t ACC_WR = 1'b1;

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_access_if.sv
// Memory-side request/acknowledge bus between the access unit (master) and
// the data memory (slave).
interface mem_access_if #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_req;
    logic              mem_we;
    logic              mem_ack;

    modport master (
        output mem_addr, mem_wdata, mem_req, mem_we,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_req, mem_we,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/mem_access_addr_gen.sv
// Byte-address former: zero-extended offset plus base scaled by 2^BASE_SHIFT,
// wrapping modulo 2^ADDR_W.
module mem_addr_gen #(
    parameter int OFFSET_W   = 12,
    parameter int BUS_W      = 16,
    parameter int ADDR_W     = 17,
    parameter int BASE_SHIFT = 1
) (
    input  logic [OFFSET_W-1:0] i_offset,
    input  logic [BUS_W-1:0]    i_base,
    output logic [ADDR_W-1:0]   o_addr
);
    logic [ADDR_W-1:0] w_off_ext;
    logic [ADDR_W-1:0] w_base_scaled;

    // The carry out of the top address bit is always discarded, so the sum is
    // formed directly at ADDR_W bits; this equals the wider sum truncated.
    assign w_off_ext     = ADDR_W'(i_offset);
    assign w_base_scaled = ADDR_W'(i_base) << BASE_SHIFT;
    assign o_addr        = w_off_ext + w_base_scaled;

endmodule

// File: rtl/mem_access_unit.sv
// Base/MDR register unit driving a req/ack data-memory port.
// Optional feature: MEM_AUTOINC_EN adds post-access base auto-increment.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int BUS_W      = 16,
    parameter int OFFSET_W   = 12,
    parameter int ADDR_W     = 17,
    parameter int NUM_BASE   = 2,
    parameter int BASE_SHIFT = 1,
    localparam int SEL_W     = sel_width(NUM_BASE)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SEL_W-1:0]    base_sel,
    input  logic                base_we,
    input  logic                mdr_src,
    input  logic                mdr_we,
    input  logic [OFFSET_W-1:0] offset,
    input  logic [BUS_W-1:0]    bus_in,
    input  logic                rd_start,
    input  logic                wr_start,
`ifdef MEM_AUTOINC_EN
    input  logic                autoinc,
`endif
    output logic [BUS_W-1:0]    base_out,
    output logic [BUS_W-1:0]    mdr_out,
    mem_access_if.master        mem,
    output logic                busy,
    output logic                done
);

    state_t            r_state;
    state_t            w_next;
    logic [BUS_W-1:0]  r_base [NUM_BASE];
    logic [DATA_W-1:0] r_mdr;
    logic [ADDR_W-1:0] r_addr;
    acc_t              r_acc;
    logic              r_done;
`ifdef MEM_AUTOINC_EN
    logic [SEL_W-1:0]  r_sel;
    logic              r_autoinc;
`endif

    logic              w_sel_ok;
    logic [BUS_W-1:0]  w_base_cur;
    logic [ADDR_W-1:0] w_addr;
    logic              w_idle;
    logic              w_start;
    logic              w_complete;
    logic              w_inc_en;

    assign w_idle     = (r_state == IDLE);
    assign w_sel_ok   = (int'(base_sel) < NUM_BASE);
    assign w_base_cur = w_sel_ok ? r_base[base_sel] : '0;
    assign w_start    = w_idle && (rd_start || wr_start);
    assign w_complete = (r_state == ACCESS) && mem.mem_ack;

`ifdef MEM_AUTOINC_EN
    assign w_inc_en = w_complete && r_autoinc;
`else
    assign w_inc_en = 1'b0;
`endif

    mem_addr_gen #(
        .OFFSET_W   (OFFSET_W),
        .BUS_W      (BUS_W),
        .ADDR_W     (ADDR_W),
        .BASE_SHIFT (BASE_SHIFT)
    ) u_addr_gen (
        .i_offset (offset),
        .i_base   (w_base_cur),
        .o_addr   (w_addr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (rd_start || wr_start) w_next = ACCESS;
            ACCESS:  if (mem.mem_ack)          w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // mem_req follows the state register so an asynchronous reset drops it at once.
    always_comb begin
        mem.mem_req = 1'b0;
        mem.mem_we  = 1'b0;
        busy        = 1'b0;
        if (r_state == ACCESS) begin
            mem.mem_req = 1'b1;
            mem.mem_we  = (r_acc == ACC_WR);
            busy        = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr <= '0;
            r_acc  <= ACC_RD;
            r_done <= 1'b0;
        end else begin
            r_done <= w_complete;
            if (w_start) begin
                r_addr <= w_addr;
                r_acc  <= rd_start ? ACC_RD : ACC_WR;
            end
        end
    end

`ifdef MEM_AUTOINC_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel     <= '0;
            r_autoinc <= 1'b0;
        end else if (w_start) begin
            r_sel     <= base_sel;
            r_autoinc <= autoinc;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mdr <= '0;
        end else if (w_complete && (r_acc == ACC_RD)) begin
            r_mdr <= mem.mem_rdata;
        end else if (w_idle && mdr_we) begin
            r_mdr <= mdr_src ? mem.mem_rdata : bus_in[DATA_W-1:0];
        end
    end

    // Direct loads are only possible in IDLE, so they never collide with the increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_BASE; i++) r_base[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_BASE; i++) begin
`ifdef MEM_AUTOINC_EN
                if (w_inc_en && (int'(r_sel) == i))
                    r_base[i] <= r_base[i] + BUS_W'(1);
                else if (w_idle && base_we && (int'(base_sel) == i))
                    r_base[i] <= bus_in;
`else
                if (!w_inc_en && w_idle && base_we && (int'(base_sel) == i))
                    r_base[i] <= bus_in;
`endif
            end
        end
    end

    assign base_out      = w_base_cur;
    assign mdr_out       = BUS_W'(r_mdr);
    assign mem.mem_addr  = r_addr;
    assign mem.mem_wdata = r_mdr;
    assign done          = r_done;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed plus randomized bench for mem_access_unit with a behavioural
// model of the base registers, MDR and address arithmetic.
module tb_mem_access_unit;

    localparam int DATA_W     = 8;
    localparam int BUS_W      = 16;
    localparam int OFFSET_W   = 12;
    localparam int ADDR_W     = 17;
    localparam int NUM_BASE   = 2;
    localparam int BASE_SHIFT = 1;

    logic                clk = 1'b0;
    logic                rst;
    logic [0:0]          base_sel;
    logic                base_we;
    logic                mdr_src;
    logic                mdr_we;
    logic [OFFSET_W-1:0] offset;
    logic [BUS_W-1:0]    bus_in;
    logic                rd_start;
    logic                wr_start;
`ifdef MEM_AUTOINC_EN
    logic                autoinc;
`endif
    logic [BUS_W-1:0]    base_out;
    logic [BUS_W-1:0]    mdr_out;
    logic                busy;
    logic                done;

    mem_access_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_if ();

    mem_access_unit #(
        .DATA_W(DATA_W), .BUS_W(BUS_W), .OFFSET_W(OFFSET_W),
        .ADDR_W(ADDR_W), .NUM_BASE(NUM_BASE), .BASE_SHIFT(BASE_SHIFT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .base_sel (base_sel),
        .base_we  (base_we),
        .mdr_src  (mdr_src),
        .mdr_we   (mdr_we),
        .offset   (offset),
        .bus_in   (bus_in),
        .rd_start (rd_start),
        .wr_start (wr_start),
`ifdef MEM_AUTOINC_EN
        .autoinc  (autoinc),
`endif
        .base_out (base_out),
        .mdr_out  (mdr_out),
        .mem      (mem_if),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [BUS_W-1:0]  base_m [NUM_BASE];
    logic [DATA_W-1:0] mdr_m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] addr_of(input logic [OFFSET_W-1:0] off, input logic [BUS_W-1:0] b);
        int unsigned full;
        full = int'(off) + int'(b) * (1 << BASE_SHIFT);
        return 32'(full % (1 << ADDR_W));
    endfunction

    // All tasks start and end just after a falling edge.
    task automatic load_base(input int sel, input logic [BUS_W-1:0] v);
        base_sel = 1'(sel);
        bus_in   = v;
        base_we  = 1'b1;
        @(negedge clk);
        base_we      = 1'b0;
        base_m[sel]  = v;
        chk("base_load", 32'(base_out), 32'(v));
    endtask

    task automatic load_mdr_bus(input logic [DATA_W-1:0] v);
        bus_in  = {8'h5A, v};
        mdr_src = 1'b0;
        mdr_we  = 1'b1;
        @(negedge clk);
        mdr_we = 1'b0;
        mdr_m  = v;
        chk("mdr_load", 32'(mdr_out), 32'(v));
    endtask

    task automatic access(input bit wr, input bit both, input int sel,
                          input logic [OFFSET_W-1:0] off, input int waits,
                          input logic [DATA_W-1:0] rdv, input bit ai, input bit inject);
        logic [31:0] exp_addr;
        bit          exp_we;
        exp_addr = addr_of(off, base_m[sel]);
        exp_we   = wr && !both;
        base_sel = 1'(sel);
        offset   = off;
        rd_start = !wr || both;
        wr_start = wr || both;
`ifdef MEM_AUTOINC_EN
        autoinc  = ai;
`endif
        @(negedge clk);
        rd_start = 1'b0;
        wr_start = 1'b0;
        for (int w = 0; w <= waits; w++) begin
            chk("acc_req",  32'(mem_if.mem_req), 32'd1);
            chk("acc_busy", 32'(busy), 32'd1);
            chk("acc_done", 32'(done), 32'd0);
            chk("acc_we",   32'(mem_if.mem_we), 32'(exp_we));
            chk("acc_addr", 32'(mem_if.mem_addr), exp_addr);
            if (exp_we) chk("acc_wdata", 32'(mem_if.mem_wdata), 32'(mdr_m));
            if (w == waits) begin
                mem_if.mem_ack   = 1'b1;
                mem_if.mem_rdata = rdv;
            end else begin
                mem_if.mem_rdata = 8'(~rdv);
            end
            rd_start = inject && (w == 0);
            base_we  = inject && (w == 0);
            bus_in   = 16'hDEAD;
            @(negedge clk);
            rd_start       = 1'b0;
            base_we        = 1'b0;
            mem_if.mem_ack = 1'b0;
        end
        if (!exp_we) mdr_m = rdv;
`ifdef MEM_AUTOINC_EN
        if (ai) base_m[sel] = base_m[sel] + 16'd1;
`endif
        chk("cpl_done", 32'(done), 32'd1);
        chk("cpl_busy", 32'(busy), 32'd0);
        chk("cpl_req",  32'(mem_if.mem_req), 32'd0);
        chk("cpl_mdr",  32'(mdr_out), 32'(mdr_m));
        chk("cpl_base", 32'(base_out), 32'(base_m[sel]));
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_req",  32'(mem_if.mem_req), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        base_sel = '0; base_we = 1'b0; mdr_src = 1'b0; mdr_we = 1'b0;
        offset = '0; bus_in = '0; rd_start = 1'b0; wr_start = 1'b0;
`ifdef MEM_AUTOINC_EN
        autoinc = 1'b0;
`endif
        mem_if.mem_ack = 1'b0; mem_if.mem_rdata = '0;
        for (int i = 0; i < NUM_BASE; i++) base_m[i] = '0;
        mdr_m = '0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < NUM_BASE; i++) begin
            base_sel = 1'(i);
            #1 chk("rst_base", 32'(base_out), 32'd0);
        end
        chk("rst_mdr",   32'(mdr_out), 32'd0);
        chk("rst_addr",  32'(mem_if.mem_addr), 32'd0);
        chk("rst_req",   32'(mem_if.mem_req), 32'd0);
        chk("rst_we",    32'(mem_if.mem_we), 32'd0);
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_done",  32'(done), 32'd0);

        // Address arithmetic, including wrap past 2^ADDR_W
        load_base(0, 16'h0010);
        access(1'b0, 1'b0, 0, 12'h005, 0, 8'h11, 1'b0, 1'b0);
        chk("addr_basic", 32'(mem_if.mem_addr), 32'h00025);
        idle_cycle();
        load_base(0, 16'hFFFF);
        access(1'b0, 1'b0, 0, 12'hFFF, 1, 8'h22, 1'b0, 1'b0);
        chk("addr_wrap", 32'(mem_if.mem_addr), 32'h00FFD);
        idle_cycle();

        // Zero-wait read
        load_base(1, 16'h0100);
        access(1'b0, 1'b0, 1, 12'h002, 0, 8'hA5, 1'b0, 1'b0);
        chk("zw_addr", 32'(mem_if.mem_addr), 32'h00202);
        chk("zw_mdr",  32'(mdr_out), 32'h00A5);
        idle_cycle();

        // Write with 3 wait states, rd_start and base_we injected while busy
        load_mdr_bus(8'h3C);
        access(1'b1, 1'b0, 1, 12'h010, 3, 8'hEE, 1'b0, 1'b1);
        idle_cycle();
        chk("busy_base_kept", 32'(base_out), 32'h0100);

        // Simultaneous starts: read wins
        access(1'b1, 1'b1, 0, 12'h123, 2, 8'h5E, 1'b0, 1'b1);
        idle_cycle();

        // mem_ack in IDLE ignored; MDR loaded from mem_rdata
        mem_if.mem_ack = 1'b1; mem_if.mem_rdata = 8'h99;
        @(negedge clk);
        mem_if.mem_ack = 1'b0;
        chk("idle_ack_done", 32'(done), 32'd0);
        chk("idle_ack_mdr",  32'(mdr_out), 32'(mdr_m));
        mem_if.mem_rdata = 8'h77; mdr_src = 1'b1; mdr_we = 1'b1;
        @(negedge clk);
        mdr_we = 1'b0; mdr_src = 1'b0; mdr_m = 8'h77;
        chk("mdr_from_rdata", 32'(mdr_out), 32'h77);

        // Back-to-back: second start in the done cycle
        access(1'b0, 1'b0, 0, 12'h001, 0, 8'h12, 1'b0, 1'b0);
        access(1'b1, 1'b0, 1, 12'h002, 0, 8'h00, 1'b0, 1'b0);
        idle_cycle();

        // Randomized traffic
        for (int k = 0; k < 30; k++) begin
            int  sel;
            bit  ai;
            sel = int'($urandom_range(0, NUM_BASE - 1));
            ai  = 1'b0;
`ifdef MEM_AUTOINC_EN
            ai  = 1'($urandom_range(0, 1));
`endif
            if ($urandom_range(0, 1) == 1) load_base(sel, 16'($urandom));
            if ($urandom_range(0, 3) == 0) load_mdr_bus(8'($urandom));
            access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0), sel,
                   12'($urandom), int'($urandom_range(0, 3)), 8'($urandom), ai,
                   1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) idle_cycle();
        end
        idle_cycle();

        // Reset in the middle of an access
        load_base(0, 16'h0042);
        load_mdr_bus(8'h81);
        base_sel = 1'b0; offset = 12'h004; rd_start = 1'b1;
        @(negedge clk);
        rd_start = 1'b0;
        chk("pre_rst_req", 32'(mem_if.mem_req), 32'd1);
        mem_if.mem_ack = 1'b1; mem_if.mem_rdata = 8'hF0;
        rst = 1'b1;
        #1;
        chk("rst_mid_req",  32'(mem_if.mem_req), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0; mem_if.mem_ack = 1'b0;
        for (int i = 0; i < NUM_BASE; i++) base_m[i] = '0;
        mdr_m = '0;
        @(negedge clk);
        chk("post_rst_mdr",  32'(mdr_out), 32'd0);
        chk("post_rst_addr", 32'(mem_if.mem_addr), 32'd0);
        chk("post_rst_done", 32'(done), 32'd0);
        for (int i = 0; i < NUM_BASE; i++) begin
            base_sel = 1'(i);
            #1 chk("post_rst_base", 32'(base_out), 32'd0);
        end
        @(negedge clk);

        // Auto-increment wraps the base; without the feature the base holds
        load_base(0, 16'hFFFF);
        access(1'b0, 1'b0, 0, 12'h000, 1, 8'h3A, 1'b1, 1'b0);
`ifdef MEM_AUTOINC_EN
        chk("autoinc_wrap", 32'(base_out), 32'h0000);
`else
        chk("no_autoinc", 32'(base_out), 32'hFFFF);
`endif
        idle_cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
